// File: rtl/common_pkg.sv
// Shared types and constants for the bus timing blocks: CPU speed encoding,
// the minimum slot length, and the speed clamp used by RTL and models alike.
package common_pkg;

   localparam int SYS_CLOCK_MHZ   = 64;
   localparam int MIN_SLOT_CYCLES = 4;

   typedef enum logic [1:0] {
      CPU_1MHZ = 2'd0,
      CPU_2MHZ = 2'd1,
      CPU_4MHZ = 2'd2,
      CPU_8MHZ = 2'd3
   } cpu_speed_t;

   // Fastest speed not above the request whose slot still spans MIN_SLOT_CYCLES.
   function automatic cpu_speed_t clamp_speed(input cpu_speed_t speed,
                                              input int sys_mhz,
                                              input int slots);
      cpu_speed_t best;
      best = CPU_1MHZ;
      for (int s = 0; s < 4; s++) begin
         if ((s <= int'(speed)) && (((sys_mhz >> s) / slots) >= MIN_SLOT_CYCLES))
            best = cpu_speed_t'(s[1:0]);
      end
      return best;
   endfunction

endpackage

// File: rtl/bus_slot_timing.sv
// Divides the system clock into bus periods of NUM_SLOTS equal slots, with
// slot strobes, CPU phi2 and a stallable CPU clock enable at selectable speed.
module bus_slot_timing #(
   parameter int SYS_CLOCK_MHZ = common_pkg::SYS_CLOCK_MHZ,
   parameter int NUM_SLOTS     = 2,
   localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [1:0]        speed_i,
   input  logic              stall_i,
   output logic [SLOT_W-1:0] slot_o,
   output logic              slot_start_o,
   output logic              slot_end_o,
   output logic              phi2_o,
   output logic              cpu_en_o,
   output logic [1:0]        speed_o
);
   import common_pkg::*;

   localparam int SYS_LOG2   = $clog2(SYS_CLOCK_MHZ);
   localparam int SLOTS_LOG2 = $clog2(NUM_SLOTS);
   localparam int CNT_W      = SYS_LOG2;

   if ((SYS_CLOCK_MHZ < 32) || ((SYS_CLOCK_MHZ & (SYS_CLOCK_MHZ - 1)) != 0)) begin : g_bad_sys
      $error("SYS_CLOCK_MHZ must be a power of two and at least 32");
   end
   if ((NUM_SLOTS < 1) || (NUM_SLOTS > 4) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0)) begin : g_bad_slots
      $error("NUM_SLOTS must be 1, 2 or 4");
   end
   if ((SYS_CLOCK_MHZ / NUM_SLOTS) < MIN_SLOT_CYCLES) begin : g_bad_slot_len
      $error("slot at 1 MHz is shorter than MIN_SLOT_CYCLES");
   end

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   cpu_speed_t        speed_q, speed_d;
   logic [CNT_W-1:0]  period_last;
   logic [CNT_W-1:0]  slot_mask;
   logic [CNT_W-1:0]  offset;
   logic [SLOT_W-1:0] slot_idx;
   logic              is_last;

   // All lengths are powers of two, so slot index and offset are shifts and masks.
   always_comb begin
      period_last = CNT_W'((SYS_CLOCK_MHZ >> int'(speed_q)) - 1);
      slot_mask   = CNT_W'((SYS_CLOCK_MHZ >> (int'(speed_q) + SLOTS_LOG2)) - 1);
      offset      = cnt_q & slot_mask;
      slot_idx    = SLOT_W'(cnt_q >> (SYS_LOG2 - SLOTS_LOG2 - int'(speed_q)));
      is_last     = (cnt_q == period_last);

      cnt_d   = is_last ? '0 : cnt_q + 1'b1;
      speed_d = is_last ? clamp_speed(cpu_speed_t'(speed_i), SYS_CLOCK_MHZ, NUM_SLOTS)
                        : speed_q;

      slot_o       = '0;
      slot_start_o = 1'b0;
      slot_end_o   = 1'b0;
      phi2_o       = 1'b0;
      cpu_en_o     = 1'b0;
      speed_o      = 2'd0;
      if (!reset_i) begin
         slot_o       = slot_idx;
         slot_start_o = (offset == '0);
         slot_end_o   = (offset == slot_mask);
         phi2_o       = (slot_idx == '0) && (offset > (slot_mask >> 1));
         cpu_en_o     = (slot_idx == '0) && (offset == slot_mask) && !stall_i;
         speed_o      = speed_q;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q   <= '0;
         speed_q <= CPU_1MHZ;
      end else begin
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
      end
   end

endmodule

// File: tb/tb_bus_slot_timing.sv
// Bench for bus_slot_timing: 2-slot and 4-slot instances share stimulus and
// are checked every cycle against a period/slot arithmetic model.
module tb_bus_slot_timing;
   import common_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] speed = 2'd0;
   logic       stall = 1'b0;

   logic [0:0] slot2;
   logic       ss2, se2, phi2_2, en2;
   logic [1:0] spd2;
   logic [1:0] slot4;
   logic       ss4, se4, phi2_4, en4;
   logic [1:0] spd4;

   int n_checks = 0;
   int n_errors = 0;

   int m_c[2];
   int m_spd[2];
   int m_slots[2] = '{2, 4};

   always #5 clk = ~clk;

   bus_slot_timing #(.SYS_CLOCK_MHZ(64), .NUM_SLOTS(2)) u_dut2 (
      .clock_i(clk), .reset_i(rst), .speed_i(speed), .stall_i(stall),
      .slot_o(slot2), .slot_start_o(ss2), .slot_end_o(se2),
      .phi2_o(phi2_2), .cpu_en_o(en2), .speed_o(spd2)
   );

   bus_slot_timing #(.SYS_CLOCK_MHZ(64), .NUM_SLOTS(4)) u_dut4 (
      .clock_i(clk), .reset_i(rst), .speed_i(speed), .stall_i(stall),
      .slot_o(slot4), .slot_start_o(ss4), .slot_end_o(se4),
      .phi2_o(phi2_4), .cpu_en_o(en4), .speed_o(spd4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk(name, act, exp);
      $display("pin %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model state advance: counter per instance, speed taken at period end.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_c[i]   = 0;
            m_spd[i] = 0;
         end else if (m_c[i] == (64 >> m_spd[i]) - 1) begin
            m_c[i]   = 0;
            m_spd[i] = int'(clamp_speed(cpu_speed_t'(speed), 64, m_slots[i]));
         end else begin
            m_c[i] = m_c[i] + 1;
         end
      end
   end

   // Compare process: expected outputs from period, slot length and offset.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int p, s, sl, off;
         logic [31:0] a_slot, a_ss, a_se, a_phi, a_en, a_spd;
         p   = 64 >> m_spd[i];
         s   = p / m_slots[i];
         sl  = m_c[i] / s;
         off = m_c[i] % s;
         if (i == 0) begin
            a_slot = 32'(slot2); a_ss = 32'(ss2); a_se = 32'(se2);
            a_phi = 32'(phi2_2); a_en = 32'(en2); a_spd = 32'(spd2);
         end else begin
            a_slot = 32'(slot4); a_ss = 32'(ss4); a_se = 32'(se4);
            a_phi = 32'(phi2_4); a_en = 32'(en4); a_spd = 32'(spd4);
         end
         chk($sformatf("n%0d.slot", m_slots[i]), a_slot, rst ? 0 : sl);
         chk($sformatf("n%0d.slot_start", m_slots[i]), a_ss, (!rst && off == 0) ? 1 : 0);
         chk($sformatf("n%0d.slot_end", m_slots[i]), a_se, (!rst && off == s - 1) ? 1 : 0);
         chk($sformatf("n%0d.phi2", m_slots[i]), a_phi, (!rst && sl == 0 && off >= s / 2) ? 1 : 0);
         chk($sformatf("n%0d.cpu_en", m_slots[i]), a_en,
             (!rst && sl == 0 && off == s - 1 && !stall) ? 1 : 0);
         chk($sformatf("n%0d.speed", m_slots[i]), a_spd, rst ? 0 : m_spd[i]);
      end
   end

   initial begin
      rst = 1'b1;
      tick(3);
      #4;
      pin("reset.slot_start", 32'(ss2), 0);
      pin("reset.speed", 32'(spd2), 0);

      // 1 MHz, 2 slots
      tick(1);
      rst = 1'b0;
      #4;
      pin("c0.slot_start", 32'(ss2), 1);
      pin("c0.slot", 32'(slot2), 0);
      tick(16); #4;
      pin("c16.phi2", 32'(phi2_2), 1);
      tick(15); #4;
      pin("c31.cpu_en", 32'(en2), 1);
      tick(1); #4;
      pin("c32.slot", 32'(slot2), 1);
      pin("c32.slot_start", 32'(ss2), 1);
      tick(224);

      // mid-period change 0 -> 2 at c=10
      tick(10);
      speed = 2'd2;
      tick(53); #4;
      pin("c63.old_speed", 32'(spd2), 0);
      pin("c63.slot_end", 32'(se2), 1);
      tick(1); #4;
      pin("new.speed_n2", 32'(spd2), 2);
      pin("new.speed_n4", 32'(spd4), 2);
      tick(3); #4;
      pin("c3.cpu_en_n4", 32'(en4), 1);
      pin("c3.cpu_en_n2", 32'(en2), 0);
      tick(4); #4;
      pin("c7.cpu_en_n2", 32'(en2), 1);

      // 8 MHz request: exact on 2 slots, clamped on 4 slots
      tick(1);
      speed = 2'd3;
      tick(8); #4;
      pin("8m.speed_n2", 32'(spd2), 3);
      pin("clamp.speed_n4", 32'(spd4), 2);
      tick(2); #4;
      pin("8m.c2.phi2", 32'(phi2_2), 1);
      tick(1); #4;
      pin("8m.c3.cpu_en_n2", 32'(en2), 1);
      pin("clamp.c3.cpu_en_n4", 32'(en4), 1);
      tick(1); #4;
      pin("8m.c4.slot", 32'(slot2), 1);

      // resync both instances at 1 MHz, then reset mid-period at c=20
      tick(1);
      speed = 2'd0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(19); #4;
      pin("c19.phi2", 32'(phi2_2), 1);
      tick(1);
      rst = 1'b1;
      #4;
      pin("rst.phi2", 32'(phi2_2), 0);
      pin("rst.slot_n4", 32'(slot4), 0);
      tick(3);
      rst = 1'b0;
      #4;
      pin("rel.slot_start", 32'(ss2), 1);
      pin("rel.speed", 32'(spd2), 0);
      tick(31); #4;
      pin("rel.c31.cpu_en", 32'(en2), 1);

      // stall across two periods, release at c=31
      tick(33);
      stall = 1'b1;
      tick(31); #4;
      pin("stall.cpu_en", 32'(en2), 0);
      pin("stall.phi2", 32'(phi2_2), 1);
      pin("stall.slot_end", 32'(se2), 1);
      tick(64); #4;
      pin("stall2.cpu_en", 32'(en2), 0);
      tick(64);
      stall = 1'b0;
      #4;
      pin("unstall.cpu_en", 32'(en2), 1);

      // randomized speed, stall and occasional reset
      for (int k = 0; k < 3000; k++) begin
         tick(1);
         if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
         stall = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 199) == 0);
      end
      tick(1);
      rst = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
